// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares one single-port synchronous instruction SRAM between the core fetch
// port (read-only) and the program loader port (read/write). Arbitration is
// per cycle and combinational. Addresses are checked before the SRAM is
// touched, and the response (read data, write ack or error) is returned
// exactly one cycle after the grant.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   boot_i                          1 = loader-only mode, fetch never granted
//   if_req_i/if_addr_i              fetch request and byte address
//   if_gnt_o                        fetch accepted this cycle
//   if_rvalid_o/if_rdata_o/if_err_o fetch response, one cycle after grant
//   ld_req_i/ld_we_i/ld_addr_i/ld_wdata_i  loader request fields
//   ld_gnt_o                        loader accepted this cycle
//   ld_rvalid_o/ld_rdata_o/ld_err_o loader response, one cycle after grant
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  SRAM command (word index)
//   mem_rdata_i                     SRAM read data, valid the cycle after a read
//
// Handshake: a requester raises *_req_i and holds it, together with all of
// its request fields, until it sees *_gnt_o high in the same cycle. The
// transfer happens in the cycle where req and gnt are both high. The
// response port (*_rvalid_o) has no back-pressure. It is high for exactly
// one cycle, and *_err_o and *_rdata_o qualify it.
module imem_arbiter #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int MEM_DEPTH = 256,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    output logic              ld_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } owner_e;

    // Upper limit for the word part of a byte address.
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(MEM_DEPTH);

    owner_e              last_owner_q;
    logic                rsp_if_q, rsp_ld_q, rsp_err_q, rsp_rd_q;

    logic                if_elig, ld_elig;
    logic                gnt_if, gnt_ld, any_gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic                acc_err;
    logic                is_write;

    always_comb begin
        if_elig = if_req_i & ~boot_i;
        ld_elig = ld_req_i;

        // The requester that did not own the last grant wins a conflict.
        gnt_if  = if_elig & (~ld_elig | (last_owner_q == OWN_LD));
        gnt_ld  = ld_elig & ~gnt_if;
        any_gnt = gnt_if | gnt_ld;

        sel_addr = gnt_ld ? ld_addr_i : if_addr_i;
        acc_err  = (sel_addr[1:0] != 2'b00) || (sel_addr[ADDR_W-1:2] >= DEPTH_LIM);
        is_write = gnt_ld & ld_we_i;

        // An erroneous access never reaches the SRAM.
        // The bus is driven to 0 whenever it is unused.
        mem_en_o    = any_gnt & ~acc_err;
        mem_we_o    = mem_en_o & is_write;
        mem_addr_o  = mem_en_o ? sel_addr[AW+1:2] : '0;
        mem_wdata_o = (mem_en_o & gnt_ld) ? ld_wdata_i : '0;
    end

    assign if_gnt_o = gnt_if;
    assign ld_gnt_o = gnt_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_LD;
            rsp_if_q     <= 1'b0;
            rsp_ld_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rd_q     <= 1'b0;
        end else begin
            if (any_gnt) begin
                last_owner_q <= gnt_ld ? OWN_LD : OWN_IF;
            end
            rsp_if_q  <= gnt_if;
            rsp_ld_q  <= gnt_ld;
            rsp_err_q <= any_gnt & acc_err;
            // Only a successful read returns SRAM data.
            rsp_rd_q  <= any_gnt & ~acc_err & ~is_write;
        end
    end

    // The SRAM presents its data in the response cycle, so the read data is
    // steered straight through. This avoids adding another cycle of latency.
    assign if_rvalid_o = rsp_if_q;
    assign if_err_o    = rsp_if_q & rsp_err_q;
    assign if_rdata_o  = (rsp_if_q & rsp_rd_q) ? mem_rdata_i : '0;
    assign ld_rvalid_o = rsp_ld_q;
    assign ld_err_o    = rsp_ld_q & rsp_err_q;
    assign ld_rdata_o  = (rsp_ld_q & rsp_rd_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int AW     = 8;
  // Packed expected response: {cycle[31:0], owner_is_ld, err, data[31:0]}
  localparam int EW     = 66;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              boot_i = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              ld_req_i = 1'b0;
  logic              ld_we_i = 1'b0;
  logic [ADDR_W-1:0] ld_addr_i = '0;
  logic [DATA_W-1:0] ld_wdata_i = '0;
  logic              if_gnt_o, if_rvalid_o, if_err_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ld_gnt_o, ld_rvalid_o, ld_err_o;
  logic [DATA_W-1:0] ld_rdata_o;
  logic              mem_en_o, mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .boot_i(boot_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o),
    .ld_rdata_o(ld_rdata_o), .ld_err_o(ld_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // SRAM macro stand-in: synchronous single port, data the cycle after read.
  logic [DATA_W-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i <= sram[mem_addr_o];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                last_ld = 1'b1;   // owner of the most recent grant
  bit                g_if, g_ld;       // model's grant decision this cycle
  int                n_checks = 0;
  int                n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model of one arbitration cycle, evaluated from the spec rules.
  task automatic score_cycle();
    bit fe, le, err, wr;
    int win;  // 0 none, 1 fetch, 2 loader
    logic [31:0] addr, data;
    int unsigned widx;
    fe  = if_req_i && !boot_i;
    le  = ld_req_i;
    win = 0;
    if (fe && le) win = last_ld ? 1 : 2;
    else if (fe)  win = 1;
    else if (le)  win = 2;
    addr = (win == 2) ? ld_addr_i : if_addr_i;
    widx = addr / 4;
    err  = (addr % 4 != 0) || (widx >= DEPTH);
    wr   = (win == 2) && ld_we_i && !err;
    g_if = (win == 1);
    g_ld = (win == 2);
    chk("if_gnt", 64'(if_gnt_o), 64'(g_if));
    chk("ld_gnt", 64'(ld_gnt_o), 64'(g_ld));
    chk("mem_en_we", 64'({mem_en_o, mem_we_o}), 64'({win != 0 && !err, wr}));
    chk("mem_addr", 64'(mem_addr_o), (win != 0 && !err) ? 64'(widx) : 64'd0);
    if (wr || win == 0) chk("mem_wdata", 64'(mem_wdata_o), wr ? 64'(ld_wdata_i) : 64'd0);
    if (win != 0) begin
      data = (err || ((win == 2) && ld_we_i)) ? 32'd0 : ref_mem[widx];
      exp_q.push_back({32'(cyc), win == 2, err, data});
      if (wr) ref_mem[widx] = ld_wdata_i;
      last_ld = (win == 2);
    end
  endtask

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (if_rvalid_o || ld_rvalid_o) begin
        if (if_rvalid_o && ld_rvalid_o) chk("single_rvalid", 64'd1, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 64'({if_rvalid_o, ld_rvalid_o}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_latency", 64'(cyc), 64'(e[65:34]) + 64'd1);
          if (e[33]) begin
            chk("ld_rsp", {30'd0, ld_rvalid_o, ld_err_o, ld_rdata_o}, {30'd0, 1'b1, e[32], e[31:0]});
            chk("if_idle", {31'd0, if_rvalid_o, if_rdata_o}, 64'd0);
          end else begin
            chk("if_rsp", {30'd0, if_rvalid_o, if_err_o, if_rdata_o}, {30'd0, 1'b1, e[32], e[31:0]});
            chk("ld_idle", {31'd0, ld_rvalid_o, ld_rdata_o}, 64'd0);
          end
        end
      end else if (exp_q.size() != 0 && e_due(exp_q[0])) begin
        chk("missing_rvalid", 64'd0, 64'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic bit e_due(input logic [EW-1:0] x);
    return (x[65:34] + 32'd1) == 32'(cyc);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic boot, input logic ifr, input logic [31:0] ifa,
                       input logic ldr, input logic ldwe, input logic [31:0] lda,
                       input logic [31:0] ldd);
    @(posedge clk); #1;
    boot_i = boot; if_req_i = ifr; if_addr_i = ifa;
    ld_req_i = ldr; ld_we_i = ldwe; ld_addr_i = lda; ld_wdata_i = ldd;
    @(negedge clk);
    score_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(boot_i, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_out"}, {30'd0, if_rvalid_o, if_err_o, if_rdata_o}, 64'd0);
    chk({tag, "_ld_out"}, {30'd0, ld_rvalid_o, ld_err_o, ld_rdata_o}, 64'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0)      return $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
    else if (r == 1) return $urandom_range(DEPTH, DEPTH + 40) * 4;
    else             return $urandom_range(0, DEPTH - 1) * 4;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic        r_boot, r_ifr, r_ldr, r_we;
    logic [31:0] r_ifa, r_lda, r_ldd;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: boot mode, loader write 0x13 @0x10 then read it back
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'h0000_0013);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0);
    idle(1);

    // 2: boot mode, fetch held 5 cycles, loader active in two of them
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 32'h20, (i == 1 || i == 2), 1'b1, 32'h40 + 32'(i) * 4, 32'hA5A5_0000 + 32'(i));
    idle(1);

    // Fill the whole array so every later read has a known value
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'(i) * 4, $urandom);
    idle(1);

    // 3: both requesting continuously, grants alternate
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'd0);
    idle(1);

    // 4: misaligned and out-of-range fetches
    drive(1'b0, 1'b1, 32'h402, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);

    // 5: preload 0xA,0xB,0xC and fetch them back-to-back
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0, 32'hA);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h4, 32'hB);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 32'hC);
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(1);

    // Randomized traffic: requests hold their fields until granted
    r_boot = 1'b0; r_ifr = 1'b0; r_ldr = 1'b0; r_we = 1'b0;
    r_ifa = '0; r_lda = '0; r_ldd = '0;
    g_if = 1'b1; g_ld = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 31) == 0) r_boot = ~r_boot;
      if (!r_ifr || g_if) begin
        r_ifr = ($urandom_range(0, 3) != 0);
        r_ifa = rand_addr();
      end
      if (!r_ldr || g_ld) begin
        r_ldr = ($urandom_range(0, 2) == 0);
        r_we  = $urandom_range(0, 1) == 1;
        r_lda = rand_addr();
        r_ldd = $urandom;
      end
      drive(r_boot, r_ifr, r_ifa, r_ldr, r_we, r_lda, r_ldd);
    end
    idle(2);

    // 6: reset in the cycle after a fetch grant drops the response
    drive(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    if_req_i = 1'b0; ld_req_i = 1'b0;
    exp_q.delete();
    last_ld = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    // First conflict after reset must go to fetch
    drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'd0);
    drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'd0);
    idle(3);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
